// File: rtl/uart_seq_pkg.sv
// Shared definitions for the uart16550 WB configuration sequencer: register map,
// bit positions and the sequencer state encoding.
package uart_seq_pkg;

  localparam logic [2:0] RBR_THR_DLL = 3'd0;
  localparam logic [2:0] IER_DLM     = 3'd1;
  localparam logic [2:0] FCR         = 3'd2;
  localparam logic [2:0] LCR         = 3'd3;
  localparam logic [2:0] LSR         = 3'd5;

  localparam int LCR_DLAB_BIT = 7;
  localparam int LSR_THRE_BIT = 5;

  // Configuration states are contiguous and CFG_IER is followed by READY.
  typedef enum logic [3:0] {
    IDLE, CFG_LCR_DLAB, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER,
    READY, RD_LSR, WR_THR
  } state_t;

  function automatic logic [7:0] lcr_dlab(input logic [7:0] lcr, input logic dlab);
    lcr_dlab = lcr;
    lcr_dlab[LCR_DLAB_BIT] = dlab;
  endfunction

endpackage

// File: rtl/uart_wb_xfer.sv
// Single-transfer Wishbone engine: launches one registered cycle per req_i while idle,
// ends it on ack (done_o, same cycle) or after ACK_TIMEOUT cycles without ack (timeout_o).
module uart_wb_xfer #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic [3:0]        wb_sel_o,
  input  logic              wb_ack_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [3:0]        sel_q;
  logic [CNT_W-1:0]  cnt_q;

  assign done_o    = cyc_q & wb_ack_i;
  assign timeout_o = cyc_q & ~wb_ack_i & (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign rdata_o   = wb_dat_i;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= 4'b0000;
      cnt_q <= '0;
    end else if (!cyc_q) begin
      if (req_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdata_i;
        sel_q <= 4'b1111;
        cnt_q <= '0;
      end
    end else if (done_o || timeout_o) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'b0000;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_wb_cfg_seq.sv
// Programs the uart16550 over WB after start, then streams tx bytes into THR.
// tx_ready only in READY with credit; credit refilled by polling LSR.THRE.
module uart_wb_cfg_seq
  import uart_seq_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       divisor,
  input  logic [7:0]        lcr_val,
  input  logic [7:0]        fcr_val,
  input  logic [7:0]        ier_val,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              err_o,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic [3:0]        wb_sel_o,
  input  logic              wb_ack_i
);

  localparam int CR_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_W-1:0] THRE_MASK = DATA_W'(1) << LSR_THRE_BIT;

  state_t          state_q;
  logic [CR_W-1:0] credit_q;
  logic [15:0]     div_q;
  logic [7:0]      lcr_q, fcr_q, ier_q, data_q;
  logic            pend_q, busy_q, done_q, err_q;

  logic              xfer_req, xfer_we, xfer_done, xfer_timeout;
  logic [ADDR_W-1:0] xfer_adr;
  logic [DATA_W-1:0] xfer_wdata, xfer_rdata;

  logic        hs, in_cfg, cap, cfg_go, thre;
  logic [15:0] go_div;

  assign tx_ready = (state_q == READY) && (credit_q != '0);
  assign hs       = tx_valid && tx_ready;
  assign in_cfg   = state_q inside {CFG_LCR_DLAB, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER};
  assign cap      = start && !in_cfg;
  assign go_div   = cap ? divisor : div_q;
  assign thre     = |(xfer_rdata & THRE_MASK);

  assign cfg_busy = busy_q;
  assign cfg_done = done_q;
  assign err_o    = err_q;

  // A start seen mid-transfer (or alongside a tx handshake) is honoured when the transfer ends.
  always_comb begin
    cfg_go = 1'b0;
    case (state_q)
      IDLE:           cfg_go = start;
      READY:          cfg_go = start && !hs;
      RD_LSR, WR_THR: cfg_go = xfer_done && (pend_q || start);
      default:        cfg_go = 1'b0;
    endcase
  end

  always_comb begin
    xfer_req   = 1'b1;
    xfer_we    = 1'b1;
    xfer_adr   = ADDR_W'(LCR);
    xfer_wdata = '0;
    case (state_q)
      CFG_LCR_DLAB: xfer_wdata = DATA_W'(lcr_dlab(lcr_q, 1'b1));
      CFG_DLL:      begin xfer_adr = ADDR_W'(RBR_THR_DLL); xfer_wdata = DATA_W'(div_q[7:0]);  end
      CFG_DLM:      begin xfer_adr = ADDR_W'(IER_DLM);     xfer_wdata = DATA_W'(div_q[15:8]); end
      CFG_LCR:      xfer_wdata = DATA_W'(lcr_dlab(lcr_q, 1'b0));
      CFG_FCR:      begin xfer_adr = ADDR_W'(FCR);         xfer_wdata = DATA_W'(fcr_q);       end
      CFG_IER:      begin xfer_adr = ADDR_W'(IER_DLM);     xfer_wdata = DATA_W'(ier_q);       end
      RD_LSR:       begin xfer_adr = ADDR_W'(LSR);         xfer_we    = 1'b0;                 end
      WR_THR:       begin xfer_adr = ADDR_W'(RBR_THR_DLL); xfer_wdata = DATA_W'(data_q);      end
      default:      xfer_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      div_q    <= '0;
      lcr_q    <= '0;
      fcr_q    <= '0;
      ier_q    <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (xfer_timeout) begin
      state_q  <= IDLE;
      credit_q <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b1;
    end else begin
      if (cap) begin
        div_q <= divisor;
        lcr_q <= lcr_val;
        fcr_q <= fcr_val;
        ier_q <= ier_val;
      end
      if (cfg_go) begin
        pend_q   <= 1'b0;
        done_q   <= 1'b0;
        credit_q <= '0;
        err_q    <= (go_div == 16'd0);
        busy_q   <= (go_div != 16'd0);
        state_q  <= (go_div == 16'd0) ? IDLE : CFG_LCR_DLAB;
      end else begin
        if (cap) pend_q <= 1'b1;
        case (state_q)
          CFG_LCR_DLAB, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER:
            if (xfer_done) begin
              state_q <= state_t'(state_q + 4'd1);
              if (state_q == CFG_IER) begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                credit_q <= '0;
              end
            end
          READY:
            if (hs) begin
              data_q  <= tx_data;
              state_q <= WR_THR;
            end else if (tx_valid && credit_q == '0) begin
              state_q <= RD_LSR;
            end
          RD_LSR:
            if (xfer_done) begin
              if (thre) credit_q <= CR_W'(FIFO_DEPTH);
              state_q <= READY;
            end
          WR_THR:
            if (xfer_done) begin
              if (credit_q != '0) credit_q <= credit_q - 1'b1;
              state_q <= READY;
            end
          default: ;
        endcase
      end
    end
  end

  uart_wb_xfer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .req_i     (xfer_req),
    .we_i      (xfer_we),
    .adr_i     (xfer_adr),
    .wdata_i   (xfer_wdata),
    .done_o    (xfer_done),
    .rdata_o   (xfer_rdata),
    .timeout_o (xfer_timeout),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i)
  );

endmodule

// File: doc/uart_wb_cfg_seq.md
Name: uart_wb_cfg_seq

Overview:
Wishbone master that configures and feeds the uart16550 through its WB slave port (8-bit data bus mode). After a start pulse it programs the divisor latch, LCR, FCR and IER. It then streams bytes from a valid/ready source into THR, polling LSR.THRE and using a 16-entry TX FIFO credit so it never overruns the UART. It sits between the SoC control logic / test sequencer and the UART WB slave.

Parameters:
ADDR_W, 3, WB address width (UART 8-bit mode register space)
DATA_W, 8, WB data width
FIFO_DEPTH, 16, UART TX FIFO depth; byte credit granted per observed THRE=1
ACK_TIMEOUT, 255, max cycles a WB cycle may wait for ack before abort (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: sample cfg inputs, begin configuration
divisor  in  16  baud divisor {DLM,DLL}
lcr_val  in  8  line control; bit 7 ignored (DLAB driven internally)
fcr_val  in  8  FIFO control value
ier_val  in  8  interrupt enable value
cfg_busy  out  1  configuration sequence in progress
cfg_done  out  1  configuration complete, streaming enabled
err_o  out  1  sticky: ack timeout or divisor==0; cleared by start
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  byte accepted when tx_valid&&tx_ready
wb_adr_o  out  ADDR_W  WB address
wb_dat_o  out  DATA_W  WB write data
wb_dat_i  in  DATA_W  WB read data
wb_we_o  out  1  WB write enable
wb_stb_o  out  1  WB strobe
wb_cyc_o  out  1  WB cycle
wb_sel_o  out  4  byte select, constant 4'b1111 while cyc, else 0
wb_ack_i  in  1  WB acknowledge

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM IDLE, credit=0, captured cfg cleared.
- All WB outputs registered. A transfer: cyc=stb=1 with adr/dat/we stable until the cycle ack is sampled high; next cycle cyc=stb=we=0 (minimum one idle cycle between transfers). Reads capture wb_dat_i on the ack cycle.
- Timeout: counter starts at cyc assertion. If ACK_TIMEOUT cycles pass without ack: drop cyc/stb, set err_o, clear cfg_done/cfg_busy, credit=0, go IDLE.
- FSM states: IDLE, CFG_LCR_DLAB, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER, READY, RD_LSR, WR_THR.
- start in IDLE or READY: latch divisor/lcr/fcr/ier, clear err_o. If divisor==0: set err_o, stay/return IDLE, no WB traffic. Otherwise cfg_busy=1 and cfg_done=0 from the next cycle.
- Config writes, in order: adr3 <= {1,lcr_val[6:0]}; adr0 <= divisor[7:0]; adr1 <= divisor[15:8]; adr3 <= {0,lcr_val[6:0]}; adr2 <= fcr_val; adr1 <= ier_val. After the IER ack: cfg_busy=0, cfg_done=1, credit=0, enter READY.
- start while cfg_busy: ignored. start in RD_LSR/WR_THR: held pending, honoured on the next entry to READY (any captured byte is written first).
- READY:
  - tx_ready = (credit>0), combinational from the state register and credit.
  - On handshake: capture tx_data, go to WR_THR (adr0, write); on ack decrement credit and return to READY.
  - If tx_valid && credit==0: go to RD_LSR (adr5, read). On ack, if rdata[5]==1 set credit=FIFO_DEPTH, else credit unchanged. Return to READY; a second poll follows if still 0.
- tx_ready is 0 in every state other than READY.
- Credit never underflows and saturates at FIFO_DEPTH.

Decomposition:
- Package uart_seq_pkg: register address constants (RBR_THR_DLL=0, IER_DLM=1, FCR=2, LCR=3, LSR=5), LCR_DLAB_BIT=7, LSR_THRE_BIT=5, state enum typedef.
- Sub-module uart_wb_xfer: single-transfer WB engine. Inputs req/we/adr/wdata; outputs done/rdata/timeout; owns the WB signals and timeout counter. The FSM sequences it.

Test Plan:
- start, divisor=16'h0145, lcr=8'h03, fcr=8'hC7, ier=8'h01, ack 1 cycle later -> writes (3,83),(0,45),(1,01),(3,03),(2,C7),(1,01) in order; cfg_done=1 after the 6th ack.
- After config, tx_valid with 20 bytes, LSR reads 8'h60 -> one LSR read; 16 THR writes; second LSR read; 4 more writes. tx_ready low during each WB cycle.
- LSR returns 8'h00 three times then 8'h60 -> 4 LSR reads; no THR write before THRE=1.
- Slave never acks on the DLM write, ACK_TIMEOUT=255 -> cyc drops after 255 cycles; err_o=1, cfg_done=0, IDLE. A subsequent start clears err_o.
- start with divisor=0 -> err_o=1, zero WB cycles.
- rst asserted during the WR_THR stall -> cyc/stb/tx_ready drop immediately (async). After release, no WB traffic until start.
